// File: rtl/cdpga_walk_check_if.sv
// Pin-test checker bus: raw pins and clear go in, lock/position/error status comes out.
interface cdpga_walk_check_if #(
   parameter int WIDTH = 21
);
   logic [WIDTH-1:0] pins_in;
   logic             clear;
   logic             locked;
   logic [4:0]       pos;
   logic             err_pulse;
   logic [15:0]      err_count;
   logic             rot_done;
   logic [15:0]      rot_count;
   logic [WIDTH-1:0] fault_mask;
   logic             timeout_flag;

   modport master (
      output pins_in, clear,
      input  locked, pos, err_pulse, err_count, rot_done, rot_count, fault_mask, timeout_flag
   );

   modport slave (
      input  pins_in, clear,
      output locked, pos, err_pulse, err_count, rot_done, rot_count, fault_mask, timeout_flag
   );
endinterface

// File: rtl/cdpga_walk_check.sv
// Far-end checker for a walking-zero pin test: filters the pins, follows the single low bit
// around the ring and records skips, bad patterns, stuck pins and stalls.
module cdpga_walk_check #(
   parameter int WIDTH          = 21,
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 2**22
) (
   input logic               clk,
   input logic               rst_n,
   cdpga_walk_check_if.slave bus
);

   localparam int CW = $clog2(STABLE_CYCLES + 2);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] STABLE_N     = CW'(STABLE_CYCLES);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [4:0]    LAST_IDX     = 5'(WIDTH - 1);

   typedef enum logic {
      SEARCH,
      TRACK
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] cand;
   logic [WIDTH-1:0] sv;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_next;
   logic             accept;
   logic             seen;
   logic             ev;

   logic [5:0]       zeros;
   logic [4:0]       idx;
   logic             valid;
   logic [4:0]       nxt;
   logic [WIDTH-1:0] expect_mask;
   logic [WIDTH-1:0] stuck_mask;

   logic [TW-1:0]    tcnt;
   logic             locked_r;
   logic [4:0]       pos_r;
   logic             err_pulse_r;
   logic [15:0]      err_count_r;
   logic             rot_done_r;
   logic [15:0]      rot_count_r;
   logic [WIDTH-1:0] fault_mask_r;
   logic             timeout_flag_r;

   // cnt saturates one above STABLE_N so a held value is accepted exactly once
   always_comb begin
      cnt_next = cnt;
      if (sync2 != cand) begin
         cnt_next = CW'(1);
      end else if (cnt <= STABLE_N) begin
         cnt_next = cnt + CW'(1);
      end
      accept = (cnt_next == STABLE_N);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '1;
         sync2 <= '1;
         cand  <= '1;
         sv    <= '1;
         cnt   <= '0;
         seen  <= 1'b0;
         ev    <= 1'b0;
      end else begin
         sync1 <= bus.pins_in;
         sync2 <= sync1;
         cand  <= sync2;
         cnt   <= cnt_next;
         ev    <= 1'b0;
         if (accept) begin
            sv   <= sync2;
            seen <= 1'b1;
            ev   <= (sync2 != sv) || !seen;
         end
      end
   end

   always_comb begin
      zeros = '0;
      idx   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (!sv[i]) begin
            zeros = zeros + 6'd1;
            idx   = 5'(i);
         end
      end
      valid       = (zeros == 6'd1);
      nxt         = (pos_r == LAST_IDX) ? 5'd0 : pos_r + 5'd1;
      expect_mask = ~(WIDTH'(1) << nxt);
      stuck_mask  = ~sv & (WIDTH'(1) << pos_r);
   end

   // clear is applied last so it overrides any same-cycle update of the sticky status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= SEARCH;
         tcnt           <= '0;
         locked_r       <= 1'b0;
         pos_r          <= '0;
         err_pulse_r    <= 1'b0;
         err_count_r    <= '0;
         rot_done_r     <= 1'b0;
         rot_count_r    <= '0;
         fault_mask_r   <= '0;
         timeout_flag_r <= 1'b0;
      end else begin
         err_pulse_r <= 1'b0;
         rot_done_r  <= 1'b0;
         case (state)
            SEARCH: begin
               tcnt <= '0;
               if (ev && valid) begin
                  pos_r    <= idx;
                  locked_r <= 1'b1;
                  state    <= TRACK;
               end
            end
            TRACK: begin
               if (ev) begin
                  tcnt <= '0;
                  if (valid && (idx == nxt)) begin
                     pos_r <= nxt;
                     if (nxt == 5'd0) begin
                        rot_done_r  <= 1'b1;
                        rot_count_r <= rot_count_r + 16'd1;
                     end
                  end else begin
                     err_pulse_r  <= 1'b1;
                     if (err_count_r != 16'hFFFF) begin
                        err_count_r <= err_count_r + 16'd1;
                     end
                     fault_mask_r <= fault_mask_r | (sv ^ expect_mask);
                     locked_r     <= 1'b0;
                     state        <= SEARCH;
                  end
               end else if (tcnt == TIMEOUT_LAST) begin
                  tcnt           <= '0;
                  err_pulse_r    <= 1'b1;
                  if (err_count_r != 16'hFFFF) begin
                     err_count_r <= err_count_r + 16'd1;
                  end
                  timeout_flag_r <= 1'b1;
                  fault_mask_r   <= fault_mask_r | stuck_mask;
                  locked_r       <= 1'b0;
                  state          <= SEARCH;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            default: state <= SEARCH;
         endcase
         if (bus.clear) begin
            err_count_r    <= '0;
            rot_count_r    <= '0;
            fault_mask_r   <= '0;
            timeout_flag_r <= 1'b0;
         end
      end
   end

   assign bus.locked       = locked_r;
   assign bus.pos          = pos_r;
   assign bus.err_pulse    = err_pulse_r;
   assign bus.err_count    = err_count_r;
   assign bus.rot_done     = rot_done_r;
   assign bus.rot_count    = rot_count_r;
   assign bus.fault_mask   = fault_mask_r;
   assign bus.timeout_flag = timeout_flag_r;

endmodule

// File: tb/tb_cdpga_walk_check.sv
// Bench for cdpga_walk_check: directed walking-zero scenarios followed by random steps,
// all compared against a step-level model of the expected lock/error behaviour.
module tb_cdpga_walk_check;

   localparam int W      = 21;
   localparam int STABLE = 4;
   localparam int TMO    = 64;
   localparam int LONG   = 90;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   cdpga_walk_check_if #(.WIDTH(W)) bus ();

   cdpga_walk_check #(
      .WIDTH(W),
      .STABLE_CYCLES(STABLE),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int errPulsesSeen = 0;
   int rotPulsesSeen = 0;

   always @(negedge clk) begin
      if (bus.err_pulse) errPulsesSeen++;
      if (bus.rot_done) rotPulsesSeen++;
   end

   logic         mLocked;
   int           mPos;
   int           mErr;
   int           mRot;
   logic [W-1:0] mFault;
   logic         mTimeout;
   int           mErrPulses = 0;
   int           mRotPulses = 0;
   logic [W-1:0] mSv;
   logic         mForce;

   function automatic logic [W-1:0] lowAt(input int i);
      logic [W-1:0] v;
      v    = '1;
      v[i] = 1'b0;
      return v;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic waitClocks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic modelReset();
      mLocked  = 1'b0;
      mPos     = 0;
      mErr     = 0;
      mRot     = 0;
      mFault   = '0;
      mTimeout = 1'b0;
      mSv      = '1;
      mForce   = 1'b1;
   endtask

   task automatic modelClear();
      mErr     = 0;
      mRot     = 0;
      mFault   = '0;
      mTimeout = 1'b0;
   endtask

   task automatic modelError();
      mErrPulses++;
      if (mErr < 65535) mErr++;
      mLocked = 1'b0;
   endtask

   // One accepted pin vector: lock on a lone low, advance on the next pin, anything else is an error
   task automatic modelEvent(input logic [W-1:0] v);
      int zeroCount;
      int zeroIdx;
      int expIdx;
      if (!mForce && v == mSv) return;
      mForce    = 1'b0;
      mSv       = v;
      zeroCount = 0;
      zeroIdx   = 0;
      for (int i = 0; i < W; i++) begin
         if (!v[i]) begin
            zeroCount++;
            zeroIdx = i;
         end
      end
      if (!mLocked) begin
         if (zeroCount == 1) begin
            mLocked = 1'b1;
            mPos    = zeroIdx;
         end
      end else begin
         expIdx = (mPos + 1) % W;
         if (zeroCount == 1 && zeroIdx == expIdx) begin
            mPos = expIdx;
            if (expIdx == 0) begin
               mRot = (mRot + 1) % 65536;
               mRotPulses++;
            end
         end else begin
            mFault = mFault | (v ^ lowAt(expIdx));
            modelError();
         end
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".locked"}, 32'(bus.locked), 32'(mLocked));
      checkOutput({tag, ".pos"}, 32'(bus.pos), 32'(mPos));
      checkOutput({tag, ".err_count"}, 32'(bus.err_count), 32'(mErr));
      checkOutput({tag, ".rot_count"}, 32'(bus.rot_count), 32'(mRot));
      checkOutput({tag, ".fault_mask"}, 32'(bus.fault_mask), 32'(mFault));
      checkOutput({tag, ".timeout_flag"}, 32'(bus.timeout_flag), 32'(mTimeout));
      checkOutput({tag, ".err_pulses"}, 32'(errPulsesSeen), 32'(mErrPulses));
      checkOutput({tag, ".rot_pulses"}, 32'(rotPulsesSeen), 32'(mRotPulses));
   endtask

   // Drive a vector for hold clocks; an optional glitch starts only after the vector is accepted
   task automatic applyStimulus(input string tag, input logic [W-1:0] v, input int hold,
                                input int glitchLen, input int glitchBit);
      logic [W-1:0] g;
      bus.pins_in = v;
      modelEvent(v);
      if (glitchLen > 0) begin
         g            = v;
         g[glitchBit] = ~g[glitchBit];
         waitClocks(8);
         bus.pins_in = g;
         waitClocks(glitchLen);
         bus.pins_in = v;
         waitClocks(hold - 8 - glitchLen);
      end else begin
         waitClocks(hold);
      end
      if (mLocked && hold >= 80) begin
         mTimeout = 1'b1;
         mFault   = mFault | ~lowAt(mPos);
         modelError();
      end
      checkAll(tag);
   endtask

   task automatic doClear();
      bus.clear = 1'b1;
      waitClocks(1);
      bus.clear = 1'b0;
      modelClear();
      waitClocks(2);
      checkAll("clear");
   endtask

   task automatic pulseReset();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      modelReset();
      checkAll("rst_async");
      @(posedge clk);
      #1 rst_n = 1'b1;
      modelEvent(bus.pins_in);
      waitClocks(12);
      checkAll("rst_relock");
   endtask

   initial begin
      int r;
      int nx;
      int other;
      logic [W-1:0] nextVec;

      bus.pins_in = '1;
      bus.clear   = 1'b0;
      modelReset();
      #12 rst_n = 1'b1;
      waitClocks(50);
      checkAll("idle");

      bus.pins_in = lowAt(0);
      modelEvent(lowAt(0));
      waitClocks(6);
      checkOutput("lat6.locked", 32'(bus.locked), 32'd0);
      waitClocks(1);
      checkOutput("lat7.locked", 32'(bus.locked), 32'd1);
      waitClocks(3);
      checkAll("walk0");
      for (int i = 1; i < W; i++) applyStimulus("walk", lowAt(i), 10, 0, 0);
      applyStimulus("wrap", lowAt(0), 10, 0, 0);
      checkOutput("wrap.rot_count", 32'(bus.rot_count), 32'd1);

      for (int i = 1; i <= 3; i++) applyStimulus("to3", lowAt(i), 10, 0, 0);
      applyStimulus("skip5", lowAt(5), 10, 0, 0);
      checkOutput("skip5.fault", 32'(bus.fault_mask), 32'h30);
      checkOutput("skip5.errs", 32'(bus.err_count), 32'd1);
      applyStimulus("relock2", lowAt(2), 10, 0, 0);
      applyStimulus("dbl37", lowAt(3) & lowAt(7), 10, 0, 0);
      checkOutput("dbl37.bit7", 32'(bus.fault_mask[7]), 32'd1);
      applyStimulus("relock8", lowAt(8), 10, 0, 0);
      applyStimulus("glitch9", lowAt(8), 16, 3, 9);
      applyStimulus("step9", lowAt(9), 10, 0, 0);
      applyStimulus("allhigh", '1, 10, 0, 0);
      applyStimulus("lock4", lowAt(4), LONG, 0, 0);
      checkOutput("stall.timeout", 32'(bus.timeout_flag), 32'd1);
      checkOutput("stall.bit4", 32'(bus.fault_mask[4]), 32'd1);
      doClear();
      checkOutput("clear.fault", 32'(bus.fault_mask), 32'd0);

      for (int i = 5; i <= 8; i++) applyStimulus("pre_rst", lowAt(i), 10, 0, 0);
      pulseReset();

      for (int n = 0; n < 160; n++) begin
         r       = int'($urandom_range(0, 99));
         nx      = (mPos + 1) % W;
         nextVec = mLocked ? lowAt(nx) : lowAt(int'($urandom_range(0, W - 1)));
         if (r < 55) begin
            applyStimulus("rnd_step", nextVec, 10, 0, 0);
         end else if (r < 65) begin
            applyStimulus("rnd_glitch", nextVec, 16, int'($urandom_range(1, 3)),
                          int'($urandom_range(0, W - 1)));
         end else if (r < 72) begin
            applyStimulus("rnd_skip", lowAt((mPos + 2 + int'($urandom_range(0, W - 3))) % W), 10, 0, 0);
         end else if (r < 78) begin
            other = (nx + 1 + int'($urandom_range(0, W - 2))) % W;
            applyStimulus("rnd_double", lowAt(nx) & lowAt(other), 10, 0, 0);
         end else if (r < 82) begin
            applyStimulus("rnd_high", '1, 10, 0, 0);
         end else if (r < 88) begin
            applyStimulus("rnd_stall", nextVec, LONG, 0, 0);
         end else if (r < 95) begin
            doClear();
         end else begin
            pulseReset();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
